// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types, defaults and wrapped-add helper for the PC generator
package pc_pkg;

    localparam int DEF_PC_W = 16;
    localparam int DEF_INC  = 2;
    localparam int MAX_W    = 64;

    typedef enum logic [2:0] {
        SEL_RST,
        SEL_EXC,
        SEL_ERET,
        SEL_RET,
        SEL_BR,
        SEL_HOLD,
        SEL_SEQ
    } pc_sel_e;

    // Sum masked to w bits; callers narrow the result to their own PC width.
    function automatic logic [MAX_W-1:0] pc_add(input logic [MAX_W-1:0] pc,
                                                input logic [MAX_W-1:0] inc,
                                                input int               w);
        logic [MAX_W-1:0] mask;
        mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
        return (pc + inc) & mask;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address stack that overwrites its oldest entry when full
module ras_stack #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             push_data,
    output logic [W-1:0]             top,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // ptr_q always addresses the most recent entry; a push pre-increments it.
    always_comb begin
        mem_d   = mem_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        if (push) begin
            ptr_d        = ptr_q + 1'b1;
            mem_d[ptr_d] = push_data;
            if (count_q != CNT_W'(DEPTH)) begin
                count_d = count_q + 1'b1;
            end
        end else if (pop && (count_q != '0)) begin
            ptr_d   = ptr_q - 1'b1;
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign top   = mem_q[ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - program counter with priority next-PC selection, RAS and exception PC
module pc_gen
    import pc_pkg::*;
#(
    parameter int              PC_W      = DEF_PC_W,
    parameter int              INC       = DEF_INC,
    parameter logic [PC_W-1:0] RESET_VEC = '0,
    parameter logic [PC_W-1:0] EXC_VEC   = PC_W'(2),
    parameter int              RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         br_taken,
    input  logic [PC_W-1:0]              br_target,
    input  logic                         call,
    input  logic                         ret,
    input  logic                         exc,
    input  logic                         eret,
    output logic [PC_W-1:0]              pc,
    output logic [PC_W-1:0]              pc_plus,
    output logic [PC_W-1:0]              epc,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_underflow
);
    pc_sel_e         sel;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] epc_q, epc_d;
    logic            underflow_q, underflow_d;
    logic            ras_push, ras_pop, ras_empty;
    logic [PC_W-1:0] ras_top;

    assign pc_plus = PC_W'(pc_add(MAX_W'(pc_q), MAX_W'(INC), PC_W));

    always_comb begin
        if (rst)           sel = SEL_RST;
        else if (exc)      sel = SEL_EXC;
        else if (eret)     sel = SEL_ERET;
        else if (ret)      sel = SEL_RET;
        else if (br_taken) sel = SEL_BR;
        else if (stall)    sel = SEL_HOLD;
        else               sel = SEL_SEQ;
    end

    always_comb begin
        pc_d        = pc_plus;
        epc_d       = epc_q;
        underflow_d = 1'b0;
        ras_push    = 1'b0;
        ras_pop     = 1'b0;
        unique case (sel)
            SEL_RST: begin
                pc_d  = RESET_VEC;
                epc_d = '0;
            end
            SEL_EXC: begin
                pc_d  = EXC_VEC;
                epc_d = pc_q;
            end
            SEL_ERET: pc_d = epc_q;
            SEL_RET: begin
                // An empty stack falls through to the next sequential PC.
                if (ras_empty) begin
                    underflow_d = 1'b1;
                end else begin
                    pc_d    = ras_top;
                    ras_pop = 1'b1;
                end
            end
            SEL_BR: begin
                pc_d     = br_target;
                ras_push = call;
            end
            SEL_HOLD: pc_d = pc_q;
            SEL_SEQ:  pc_d = pc_plus;
            default:  pc_d = pc_plus;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_VEC;
            epc_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            epc_q       <= epc_d;
            underflow_q <= underflow_d;
        end
    end

    ras_stack #(
        .W     (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus),
        .top       (ras_top),
        .count     (ras_count),
        .empty     (ras_empty)
    );

    assign pc            = pc_q;
    assign epc           = epc_q;
    assign ras_underflow = underflow_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed and randomized check of pc_gen against a queue-based model
module tb_pc_gen;

    localparam int          DEPTH = 4;
    localparam logic [15:0] RV    = 16'h0000;
    localparam logic [15:0] EV    = 16'h0002;

    logic        clk = 1'b0;
    logic        rst, stall, br_taken, call, ret, exc, eret;
    logic [15:0] br_target;
    logic [15:0] pc, pc_plus, epc;
    logic [2:0]  ras_count;
    logic        ras_underflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_pc, m_epc;
    logic [15:0] m_ras [$];
    bit          m_und;

    always #5 clk = ~clk;

    pc_gen #(
        .PC_W      (16),
        .INC       (2),
        .RESET_VEC (RV),
        .EXC_VEC   (EV),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .br_taken      (br_taken),
        .br_target     (br_target),
        .call          (call),
        .ret           (ret),
        .exc           (exc),
        .eret          (eret),
        .pc            (pc),
        .pc_plus       (pc_plus),
        .epc           (epc),
        .ras_count     (ras_count),
        .ras_underflow (ras_underflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_update();
        m_und = 1'b0;
        if (rst) begin
            m_pc  = RV;
            m_epc = 16'h0;
            m_ras.delete();
        end else if (exc) begin
            m_epc = m_pc;
            m_pc  = EV;
        end else if (eret) begin
            m_pc = m_epc;
        end else if (ret) begin
            if (m_ras.size() > 0) begin
                m_pc = m_ras.pop_back();
            end else begin
                m_pc  = 16'(m_pc + 16'd2);
                m_und = 1'b1;
            end
        end else if (br_taken) begin
            if (call) begin
                m_ras.push_back(16'(m_pc + 16'd2));
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end
            m_pc = br_target;
        end else if (!stall) begin
            m_pc = 16'(m_pc + 16'd2);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check("pc", 32'(pc), 32'(m_pc));
        check("pc_plus", 32'(pc_plus), 32'(16'(m_pc + 16'd2)));
        check("epc", 32'(epc), 32'(m_epc));
        check("ras_count", 32'(ras_count), 32'(m_ras.size()));
        check("ras_underflow", 32'(ras_underflow), 32'(m_und));
    endtask

    task automatic cyc(input bit r_, input bit s_, input bit b_, input bit c_,
                       input bit rt_, input bit e_, input bit er_, input logic [15:0] t_);
        rst = r_; stall = s_; br_taken = b_; call = c_;
        ret = rt_; exc = e_; eret = er_; br_target = t_;
        step();
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 16'h0);
    endtask

    task automatic jump(input logic [15:0] t);
        cyc(0, 0, 1, 0, 0, 0, 0, t);
    endtask

    logic [15:0] ret_exp [4];

    initial begin
        rst = 1'b1; stall = 1'b0; br_taken = 1'b0; call = 1'b0;
        ret = 1'b0; exc = 1'b0; eret = 1'b0; br_target = 16'h0;
        m_pc = 16'h0; m_epc = 16'h0; m_und = 1'b0;

        // reset then sequential
        cyc(1, 0, 0, 0, 0, 0, 0, 16'h0);
        cyc(1, 0, 0, 0, 0, 0, 0, 16'h0);
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_cnt", 32'(ras_count), 32'h0);
        idle(); idle(); idle();
        check("seq_pc", 32'(pc), 32'h6);

        // stall holds, redirect overrides stall
        jump(16'h0008);
        cyc(0, 1, 0, 0, 0, 0, 0, 16'h0);
        cyc(0, 1, 0, 0, 0, 0, 0, 16'h0);
        check("stall_pc", 32'(pc), 32'h8);
        cyc(0, 1, 1, 0, 0, 0, 0, 16'h0040);
        check("stall_br_pc", 32'(pc), 32'h40);

        // nested calls overflow the stack, then returns drain it
        jump(16'h0010);
        for (int k = 2; k <= 6; k++) cyc(0, 0, 1, 1, 0, 0, 0, 16'(k * 16'h10));
        check("call_cnt_sat", 32'(ras_count), 32'h4);
        check("call_pc", 32'(pc), 32'h60);
        ret_exp[0] = 16'h52; ret_exp[1] = 16'h42; ret_exp[2] = 16'h32; ret_exp[3] = 16'h22;
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 0, 0, 1, 0, 0, 16'h0);
            check("ret_pc", 32'(pc), 32'(ret_exp[k]));
        end
        cyc(0, 0, 0, 0, 1, 0, 0, 16'h0);
        check("uf_pc", 32'(pc), 32'h24);
        check("uf_pulse", 32'(ras_underflow), 32'h1);
        idle();
        check("uf_clear", 32'(ras_underflow), 32'h0);

        // exception round trip
        jump(16'h1234);
        cyc(0, 0, 0, 0, 0, 1, 0, 16'h0);
        check("exc_pc", 32'(pc), 32'(EV));
        check("exc_epc", 32'(epc), 32'h1234);
        idle(); idle();
        cyc(0, 0, 0, 0, 0, 0, 1, 16'h0);
        check("eret_pc", 32'(pc), 32'h1234);
        check("eret_epc", 32'(epc), 32'h1234);

        // everything at once: exception wins; then ret beats call
        cyc(0, 0, 1, 1, 0, 0, 0, 16'h0100);
        cyc(0, 1, 1, 1, 1, 1, 1, 16'h0300);
        check("prio_pc", 32'(pc), 32'(EV));
        check("prio_epc", 32'(epc), 32'h100);
        check("prio_cnt", 32'(ras_count), 32'h1);
        cyc(0, 0, 1, 1, 1, 0, 0, 16'h0500);
        check("retcall_pc", 32'(pc), 32'h1236);
        check("retcall_cnt", 32'(ras_count), 32'h0);

        // wrap and reset coincident with call
        jump(16'hFFFE);
        idle();
        check("wrap_pc", 32'(pc), 32'h0);
        jump(16'h0200);
        cyc(1, 0, 1, 1, 0, 1, 0, 16'h0700);
        check("rst_call_pc", 32'(pc), 32'(RV));
        check("rst_call_cnt", 32'(ras_count), 32'h0);
        cyc(0, 0, 0, 0, 1, 0, 0, 16'h0);
        check("rst_call_nopush", 32'(ras_underflow), 32'h1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(63) == 0),
                ($urandom_range(3) == 0),
                ($urandom_range(3) == 0),
                ($urandom_range(1) == 0),
                ($urandom_range(4) == 0),
                ($urandom_range(15) == 0),
                ($urandom_range(15) == 0),
                16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
